// File: rtl/oflow_iou_min_select_if.sv
// Handshake and result bundle between the IoU-cost stage, the min-select block and
// the object-matching logic.
interface oflow_iou_min_select_if #(
  parameter int IOU_LEN = 22,
  parameter int IDX_W   = 5
);
  logic               start;
  logic [IDX_W:0]     num_candidates;
  logic [IOU_LEN-1:0] cost_threshold;
  logic               valid_iou;
  logic [IOU_LEN-1:0] iou;
  logic               busy;
  logic               done;
  logic [IDX_W-1:0]   best_idx;
  logic [IOU_LEN-1:0] best_cost;
  logic               match_found;
  logic               err_overrun;

  modport master (
    output start, num_candidates, cost_threshold, valid_iou, iou,
    input  busy, done, best_idx, best_cost, match_found, err_overrun
  );

  modport slave (
    input  start, num_candidates, cost_threshold, valid_iou, iou,
    output busy, done, best_idx, best_cost, match_found, err_overrun
  );
endinterface

// File: rtl/oflow_iou_min_select.sv
// Streams 1-IoU costs for one object's history candidates, keeps the running
// minimum (earliest index wins ties) and reports it with a threshold match flag.
module oflow_iou_min_select #(
  parameter int IOU_LEN     = 22,
  parameter int MAX_HISTORY = 32,
  parameter int IDX_W       = 5
) (
  input logic                   clk,
  input logic                   reset_N,
  oflow_iou_min_select_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [IDX_W:0]     MAX_CNT  = (IDX_W+1)'(MAX_HISTORY);
  localparam logic [IOU_LEN-1:0] ALL_ONES = {IOU_LEN{1'b1}};

  state_t             state_q, state_d;
  logic [IDX_W:0]     cnt_q, cnt_d;
  logic [IDX_W:0]     count_q, count_d;
  logic [IOU_LEN-1:0] thr_q, thr_d;
  logic [IOU_LEN-1:0] min_q, min_d;
  logic [IDX_W-1:0]   min_idx_q, min_idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [IOU_LEN-1:0] best_cost_q, best_cost_d;
  logic               match_q, match_d;
  logic               err_q, err_d;

  // Next-state and next-output computation for the search sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    count_d     = count_q;
    thr_d       = thr_q;
    min_d       = min_q;
    min_idx_d   = min_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    best_idx_d  = best_idx_q;
    best_cost_d = best_cost_q;
    match_d     = match_q;
    err_d       = err_q;

    // A start outside IDLE (including the DONE cycle) is dropped but remembered.
    if (bus.start && (state_q != IDLE)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          thr_d     = bus.cost_threshold;
          min_d     = ALL_ONES;
          min_idx_d = {IDX_W{1'b0}};
          cnt_d     = {(IDX_W+1){1'b0}};
          busy_d    = 1'b1;
          match_d   = 1'b0;
          if (bus.num_candidates > MAX_CNT) begin
            count_d = MAX_CNT;
            err_d   = 1'b1;
          end else begin
            count_d = bus.num_candidates;
          end
          if (bus.num_candidates == {(IDX_W+1){1'b0}}) begin
            state_d = DECIDE;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (bus.valid_iou) begin
          // Strict compare keeps the earlier index on equal costs.
          if (bus.iou < min_q) begin
            min_d     = bus.iou;
            min_idx_d = cnt_q[IDX_W-1:0];
          end else begin
            min_d     = min_q;
            min_idx_d = min_idx_q;
          end
          cnt_d = cnt_q + {{IDX_W{1'b0}}, 1'b1};
          if ((cnt_q + {{IDX_W{1'b0}}, 1'b1}) == count_q) begin
            state_d = DECIDE;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      DECIDE: begin
        best_idx_d  = min_idx_q;
        best_cost_d = min_q;
        match_d     = (count_q != {(IDX_W+1){1'b0}}) && (min_q <= thr_q);
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_N) begin
      state_q     <= IDLE;
      cnt_q       <= {(IDX_W+1){1'b0}};
      count_q     <= {(IDX_W+1){1'b0}};
      thr_q       <= {IOU_LEN{1'b0}};
      min_q       <= ALL_ONES;
      min_idx_q   <= {IDX_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      best_idx_q  <= {IDX_W{1'b0}};
      best_cost_q <= ALL_ONES;
      match_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      count_q     <= count_d;
      thr_q       <= thr_d;
      min_q       <= min_d;
      min_idx_q   <= min_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      best_idx_q  <= best_idx_d;
      best_cost_q <= best_cost_d;
      match_q     <= match_d;
      err_q       <= err_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.best_idx    = best_idx_q;
  assign bus.best_cost   = best_cost_q;
  assign bus.match_found = match_q;
  assign bus.err_overrun = err_q;

endmodule

// File: doc/oflow_iou_min_select.md
Name: oflow_iou_min_select

Overview:
- Downstream consumer of the IoU-cost stage. Each cost it receives is 1 − IoU in q0.22; a smaller value means more overlap.
- For one current-frame object, collects the costs for up to MAX_HISTORY history candidates, which arrive serially in candidate order.
- Selects the candidate with the minimum cost and compares that cost against a threshold.
- Emits the best history index, the best cost, and a match flag to the object-matching logic.

Parameters:
- IOU_LEN, 22, width of the cost input (q0.22).
- MAX_HISTORY, 32, maximum number of history candidates per object.
- IDX_W, 5, index width, equal to clog2(MAX_HISTORY).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_N  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse that begins a new object search.
- num_candidates  in  IDX_W+1  number of costs expected (0..MAX_HISTORY); sampled on start.
- cost_threshold  in  IOU_LEN  maximum accepted cost; sampled on start.
- valid_iou  in  1  cost-valid strobe from the IoU stage.
- iou  in  IOU_LEN  cost value (1 − IoU, q0.22).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle.
- best_idx  out  IDX_W  arrival index (0-based) of the minimum-cost candidate.
- best_cost  out  IOU_LEN  minimum cost seen.
- match_found  out  1  best_cost <= cost_threshold, and at least one candidate.
- err_overrun  out  1  sticky flag: start arrived while busy, or num_candidates > MAX_HISTORY.

Behaviour:
- Reset values: busy=0, done=0, best_idx=0, best_cost={IOU_LEN{1}}, match_found=0, err_overrun=0. State goes to IDLE and the internal counter to 0.
- Reset in mid-search aborts the search immediately. No done pulse is produced.
- States: IDLE, COLLECT, DECIDE, DONE.
- IDLE:
  - On start, latch num_candidates and cost_threshold.
  - Set the running minimum to all-ones, running index to 0, counter to 0.
  - If num_candidates == 0, go to DECIDE. Otherwise go to COLLECT.
  - If num_candidates > MAX_HISTORY, set err_overrun and clamp the latched count to MAX_HISTORY.
  - valid_iou in IDLE is ignored.
- COLLECT, on each valid_iou:
  - If iou < running minimum (strict), update the minimum to iou and the index to counter.
  - Increment counter.
  - When counter reaches count−1 on an accepted valid_iou, go to DECIDE.
- Tie rule: equal costs keep the earlier (lower) index.
- A cost of all-ones (no overlap) is a legal candidate. It is selected only if all candidates are all-ones; the index is then 0.
- DECIDE, exactly 1 cycle:
  - Register best_idx and best_cost.
  - match_found = (count != 0) && (min <= threshold).
  - Go to DONE.
- DONE, 1 cycle:
  - done=1 and busy=0 in this cycle.
  - Return to IDLE.
  - Outputs hold until the next accepted start, which clears match_found to 0 on the following cycle.
- Latency: done asserts 2 cycles after the clock edge that sampled the last valid_iou. For num_candidates == 0, done asserts 2 cycles after the start edge.
- start while busy (COLLECT/DECIDE/DONE):
  - Ignored; err_overrun set (sticky until reset).
  - The current search continues unaffected.
- start coincident with done (in DONE) counts as busy. The IoU producer must wait for done before issuing start.
- valid_iou beyond the expected count is impossible: the state has already left COLLECT, so it is ignored.
- Arithmetic: unsigned compares only; no subtraction. The counter is IDX_W+1 bits, so 32 candidates do not wrap.

Test Plan:
- start, num_candidates=4, threshold=0x100000; costs 0x3FFFFF, 0x0A0000, 0x200000, 0x0A0000 → best_idx=1, best_cost=0x0A0000, match_found=1, done exactly 2 cycles after the 4th valid.
- num_candidates=3, threshold=0x010000; costs 0x300000, 0x250000, 0x280000 → best_idx=1, best_cost=0x250000, match_found=0.
- num_candidates=0 → done 2 cycles after start, best_cost=0x3FFFFF, best_idx=0, match_found=0.
- num_candidates=32 with the minimum 0x000001 at index 31; also gaps of 0–3 idle cycles between valid_iou pulses → best_idx=31, match_found=1, no counter wrap.
- start pulsed during COLLECT of a 3-candidate search → err_overrun=1, original result unchanged. num_candidates=40 → err_overrun=1, done after 32 costs.
- reset_N asserted after 2 of 4 costs, then a new 1-candidate search with cost 0x000000 → all outputs at reset values during reset, then best_idx=0, best_cost=0, match_found=1.
